// File: rtl/uart_rx_sampler_pkg.sv
// Shared types and defaults for the oversampled UART receive front end.
// UART_RX_PARITY_EN (when defined) enables the even-parity bit between data and stop.
package uart_rx_sampler_pkg;

  localparam int DEF_OVERSAMPLE_DIV = 52;
  localparam int OVERSAMPLE         = 16;
  localparam int DATA_BITS          = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_BREAK  = 3'd5
  } state_t;

  // Even parity: data ones plus parity bit must be even, so an odd total is an error.
  function automatic logic even_parity_err(input logic [DATA_BITS-1:0] data,
                                           input logic par_bit);
    return (^data) ^ par_bit;
  endfunction

endpackage

// File: rtl/uart_rx_sampler_if.sv
// Byte handshake between the receive sampler (master) and the register block (slave).
// UART_RX_PARITY_EN adds the o_parity_err status line.
interface uart_rx_sampler_if;
  import uart_rx_sampler_pkg::*;

  logic                 i_rx_ack;
  logic [DATA_BITS-1:0] o_rx_data;
  logic                 o_rx_valid;
  logic                 o_frame_err;
  logic                 o_overrun;
  logic                 o_busy;
`ifdef UART_RX_PARITY_EN
  logic                 o_parity_err;
`endif

  modport master (
    input  i_rx_ack,
    output o_rx_data, o_rx_valid, o_frame_err, o_overrun, o_busy
`ifdef UART_RX_PARITY_EN
    , output o_parity_err
`endif
  );

  modport slave (
    output i_rx_ack,
    input  o_rx_data, o_rx_valid, o_frame_err, o_overrun, o_busy
`ifdef UART_RX_PARITY_EN
    , input o_parity_err
`endif
  );

endinterface

// File: rtl/uart_rx_sampler_baud_tick.sv
// Free-running oversample divider; tick_en_o pulses one clk every DIV clks.
// Shared with the transmit side.
module uart_baud_tick #(
  parameter int DIV = 52
) (
  input  logic clk,
  input  logic reset,
  output logic tick_en_o
);

  localparam logic [7:0] LAST_CNT = 8'(DIV - 1);

  logic [7:0] cnt_q, cnt_d;
  logic       tick_q;

  // Next divider count, wrapping at DIV-1.
  always_comb begin
    if (cnt_q == LAST_CNT) begin
      cnt_d = 8'd0;
    end else begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  // Divider state and registered tick strobe.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q  <= 8'd0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= (cnt_q == LAST_CNT);
    end
  end

  assign tick_en_o = tick_q;

endmodule

// File: rtl/uart_rx_sampler.sv
// Oversampled UART receiver: synchronise, validate start, mid-bit sample, check stop, deliver.
// UART_RX_PARITY_EN inserts an even-parity bit and drives o_parity_err.
module uart_rx_sampler
  import uart_rx_sampler_pkg::*;
#(
  parameter int OVERSAMPLE_DIV = DEF_OVERSAMPLE_DIV
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_UART_TX,
  uart_rx_sampler_if.master  rx_if
);

  localparam logic [3:0] MID_TICK  = 4'(OVERSAMPLE / 2 - 1);
  localparam logic [3:0] LAST_TICK = 4'(OVERSAMPLE - 1);
  localparam logic [3:0] LAST_BIT  = 4'(DATA_BITS - 1);

  logic                 tick_en;
  logic                 sync1_q, sync2_q;
  logic                 rx_s;
  state_t               state_q;
  logic [3:0]           samp_q;
  logic [3:0]           bit_q;
  logic [DATA_BITS-1:0] shreg_q;
  logic                 stop_q;
  logic                 deliver_q;
  logic                 busy_q;
  logic [DATA_BITS-1:0] data_q;
  logic                 valid_q;
  logic                 ferr_q;
  logic                 ovr_q;
`ifdef UART_RX_PARITY_EN
  logic                 par_q;
  logic                 perr_q;
`endif

  uart_baud_tick #(.DIV(OVERSAMPLE_DIV)) u_tick (
    .clk       (clk),
    .reset     (reset),
    .tick_en_o (tick_en)
  );

  assign rx_s = sync2_q;

  // Synchroniser and receive FSM; all state moves happen on tick_en.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      state_q   <= ST_IDLE;
      samp_q    <= 4'd0;
      bit_q     <= 4'd0;
      shreg_q   <= '0;
      stop_q    <= 1'b1;
      deliver_q <= 1'b0;
      busy_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q     <= 1'b0;
`endif
    end else begin
      sync1_q   <= i_UART_TX;
      sync2_q   <= sync1_q;
      deliver_q <= 1'b0;
      if (tick_en) begin
        case (state_q)
          ST_IDLE: begin
            if (!rx_s) begin
              state_q <= ST_START;
              samp_q  <= 4'd0;
              busy_q  <= 1'b1;
            end
          end
          ST_START: begin
            if (samp_q == MID_TICK) begin
              samp_q <= 4'd0;
              if (!rx_s) begin
                state_q <= ST_DATA;
                bit_q   <= 4'd0;
              end else begin
                state_q <= ST_IDLE;
                busy_q  <= 1'b0;
              end
            end else begin
              samp_q <= samp_q + 4'd1;
            end
          end
          ST_DATA: begin
            if (samp_q == LAST_TICK) begin
              samp_q  <= 4'd0;
              shreg_q <= {rx_s, shreg_q[DATA_BITS-1:1]};
              bit_q   <= bit_q + 4'd1;
              if (bit_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                state_q <= ST_PARITY;
`else
                state_q <= ST_STOP;
`endif
              end
            end else begin
              samp_q <= samp_q + 4'd1;
            end
          end
`ifdef UART_RX_PARITY_EN
          ST_PARITY: begin
            if (samp_q == LAST_TICK) begin
              samp_q  <= 4'd0;
              par_q   <= rx_s;
              state_q <= ST_STOP;
            end else begin
              samp_q <= samp_q + 4'd1;
            end
          end
`endif
          ST_STOP: begin
            if (samp_q == LAST_TICK) begin
              samp_q    <= 4'd0;
              stop_q    <= rx_s;
              deliver_q <= 1'b1;
              if (rx_s) begin
                state_q <= ST_IDLE;
                busy_q  <= 1'b0;
              end else begin
                state_q <= ST_BREAK;
              end
            end else begin
              samp_q <= samp_q + 4'd1;
            end
          end
          // A held-low line parks here so it cannot be read as a stream of zero frames.
          ST_BREAK: begin
            if (rx_s) begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
            end
          end
          default: begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  // Byte handshake: load on deliver when free or acked this clk, else flag overrun.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_q  <= 1'b0;
`endif
    end else if (deliver_q) begin
      if (!valid_q || rx_if.i_rx_ack) begin
        data_q  <= shreg_q;
        ferr_q  <= ~stop_q;
        valid_q <= 1'b1;
        ovr_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
        perr_q  <= even_parity_err(shreg_q, par_q);
`endif
      end else begin
        ovr_q <= 1'b1;
      end
    end else if (rx_if.i_rx_ack && valid_q) begin
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end
  end

  assign rx_if.o_rx_data   = data_q;
  assign rx_if.o_rx_valid  = valid_q;
  assign rx_if.o_frame_err = ferr_q;
  assign rx_if.o_overrun   = ovr_q;
  assign rx_if.o_busy      = busy_q;
`ifdef UART_RX_PARITY_EN
  assign rx_if.o_parity_err = perr_q;
`endif

endmodule

// File: tb/tb_uart_rx_sampler.sv
// Self-checking bench for uart_rx_sampler: directed frames plus random bytes against a
// byte-level handshake model. Honours UART_RX_PARITY_EN for the parity bit and o_parity_err.
module tb_uart_rx_sampler;
  import uart_rx_sampler_pkg::*;

  // Divider shortened from 52 to keep the run short; latency bound scales with it.
  localparam int DIV         = 13;
  localparam int BIT_CLK     = DIV * OVERSAMPLE;
  localparam int LAT_BOUND   = 8000 * DIV / 52;

  logic clk     = 1'b0;
  logic reset   = 1'b0;
  logic uart_tx = 1'b1;

  uart_rx_sampler_if rx_if ();

  uart_rx_sampler #(.OVERSAMPLE_DIV(DIV)) dut (
    .clk       (clk),
    .reset     (reset),
    .i_UART_TX (uart_tx),
    .rx_if     (rx_if)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] m_data;
  bit         m_valid, m_ferr, m_ovr;
`ifdef UART_RX_PARITY_EN
  bit         m_perr;
`endif

  int cyc, rise_cyc;
  bit ack_arm, prev_busy, prev_valid;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_data = 8'h00; m_valid = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0;
`ifdef UART_RX_PARITY_EN
    m_perr = 1'b0;
`endif
  endtask

  task automatic model_deliver(input logic [7:0] b, input bit ferr, input bit perr, input bit ack_same);
    if (!m_valid || ack_same) begin
      m_data = b; m_ferr = ferr; m_valid = 1'b1; m_ovr = 1'b0;
`ifdef UART_RX_PARITY_EN
      m_perr = perr;
`endif
    end else begin
      m_ovr = 1'b1;
    end
    if (perr) begin end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, "_data"},  rx_if.o_rx_data,   m_data);
    chk({tag, "_valid"}, rx_if.o_rx_valid,  m_valid);
    chk({tag, "_ferr"},  rx_if.o_frame_err, m_ferr);
    chk({tag, "_ovr"},   rx_if.o_overrun,   m_ovr);
    chk({tag, "_busy"},  rx_if.o_busy,      1'b0);
`ifdef UART_RX_PARITY_EN
    chk({tag, "_perr"},  rx_if.o_parity_err, m_perr);
`endif
  endtask

  // Drive the line for n clks; optionally fire ack on the clk the byte is delivered.
  task automatic drive(input logic level, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      uart_tx        = level;
      rx_if.i_rx_ack = 1'b0;
      if (ack_arm && prev_busy && !rx_if.o_busy) begin
        rx_if.i_rx_ack = 1'b1;
        ack_arm        = 1'b0;
      end
      if (!prev_valid && rx_if.o_rx_valid && rise_cyc < 0) rise_cyc = cyc;
      prev_busy  = rx_if.o_busy;
      prev_valid = rx_if.o_rx_valid;
      cyc++;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input bit stop_lvl, input int low_bits,
                            input bit bad_par, input bit ack_same);
    cyc        = 0;
    rise_cyc   = -1;
    prev_busy  = rx_if.o_busy;
    prev_valid = rx_if.o_rx_valid;
    ack_arm    = ack_same;
    drive(1'b0, BIT_CLK);
    for (int i = 0; i < 8; i++) drive(b[i], BIT_CLK);
`ifdef UART_RX_PARITY_EN
    drive((^b) ^ bad_par, BIT_CLK);
    model_deliver(b, !stop_lvl, bad_par, ack_same);
`else
    model_deliver(b, !stop_lvl, 1'b0, ack_same);
`endif
    if (stop_lvl) begin
      drive(1'b1, BIT_CLK);
    end else begin
      drive(1'b0, BIT_CLK * low_bits);
      drive(1'b1, BIT_CLK);
    end
    drive(1'b1, 60);
  endtask

  task automatic pulse_ack();
    @(negedge clk);
    rx_if.i_rx_ack = 1'b1;
    @(negedge clk);
    rx_if.i_rx_ack = 1'b0;
    if (m_valid) begin
      m_valid = 1'b0;
      m_ovr   = 1'b0;
    end
  endtask

  initial begin
    logic [7:0] rb;
    bit         rstop, rack, rpar;
    rx_if.i_rx_ack = 1'b0;
    ack_arm        = 1'b0;
    model_reset();

    // Reset state
    repeat (3) @(negedge clk);
    check_outputs("rst");
    reset = 1'b1;
    drive(1'b1, 100);

    // 1: clean 0xA5 with latency bound
    send_frame(8'hA5, 1'b1, 0, 1'b0, 1'b0);
    check_outputs("t1");
    chk("t1_latency_ok", (rise_cyc >= 0 && rise_cyc <= LAT_BOUND), 1'b1);
    pulse_ack();
    check_outputs("t1_ack");

    // 2: short low glitch is a false start
    drive(1'b0, 35);
    chk("t2_busy_in_glitch", rx_if.o_busy, 1'b1);
    drive(1'b0, 15);
    drive(1'b1, 4 * BIT_CLK);
    check_outputs("t2");

    // 3: stop low with line held low 3 bit times, then a clean byte
    send_frame(8'h3C, 1'b0, 3, 1'b0, 1'b0);
    check_outputs("t3_break");
    pulse_ack();
    drive(1'b1, 2 * BIT_CLK);
    check_outputs("t3_norepeat");
    send_frame(8'h55, 1'b1, 0, 1'b0, 1'b0);
    check_outputs("t3_next");
    pulse_ack();

    // 4: overrun, then ack clears valid and overrun but holds data
    send_frame(8'h11, 1'b1, 0, 1'b0, 1'b0);
    send_frame(8'h22, 1'b1, 0, 1'b0, 1'b0);
    check_outputs("t4_ovr");
    pulse_ack();
    check_outputs("t4_ack");

    // 5: ack coincident with deliver loads the new byte without overrun
    send_frame(8'h11, 1'b1, 0, 1'b0, 1'b0);
    send_frame(8'h22, 1'b1, 0, 1'b0, 1'b1);
    check_outputs("t5");
    pulse_ack();

    // 6: reset mid-DATA of 0xFF, then 0x81 (bad parity when enabled)
    cyc = 0; rise_cyc = -1; ack_arm = 1'b0;
    drive(1'b0, BIT_CLK);
    drive(1'b1, 2 * BIT_CLK + 50);
    chk("t6_busy_before_rst", rx_if.o_busy, 1'b1);
    @(negedge clk);
    reset = 1'b0;
    #1;
    model_reset();
    check_outputs("t6_in_rst");
    repeat (5) @(negedge clk);
    reset = 1'b1;
    drive(1'b1, 8 * BIT_CLK);
    check_outputs("t6_after_rst");
    send_frame(8'h81, 1'b1, 0, 1'b1, 1'b0);
    check_outputs("t6_next");
    pulse_ack();

    // Random frames with random stop level, parity and ack pattern
    for (int k = 0; k < 8; k++) begin
      rb    = 8'($urandom_range(0, 255));
      rstop = ($urandom_range(0, 3) != 0);
      rack  = ($urandom_range(0, 3) == 0);
      rpar  = ($urandom_range(0, 3) == 0);
      send_frame(rb, rstop, 1, rpar, rack);
      check_outputs("rnd");
      if ($urandom_range(0, 1) == 1) begin
        pulse_ack();
        check_outputs("rnd_ack");
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
